// File: rtl/branch_resolve_unit_pkg.sv
// Purpose     : shared constants and helpers for the branch resolve unit and its BHT.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: bru_op one-hot bit positions, the conditional-op mask, the BHT
// counter reset value, and the 2-bit saturating counter step function.
package branch_resolve_unit_pkg;

  // Width of the one-hot bru_op vector.
  localparam int BRU_OP_W = 8;

  // Bit positions inside bru_op = {jal,jalr,beq,bne,blt,bge,bltu,bgeu}.
  localparam int OP_JAL  = 7;
  localparam int OP_JALR = 6;
  localparam int OP_BEQ  = 5;
  localparam int OP_BNE  = 4;
  localparam int OP_BLT  = 3;
  localparam int OP_BGE  = 2;
  localparam int OP_BLTU = 1;
  localparam int OP_BGEU = 0;

  // Ops that train the BHT. Unconditional jumps are excluded on purpose:
  // they are always taken and would only pollute the counters.
  localparam logic [BRU_OP_W-1:0] COND_OP_MASK = 8'b0011_1111;

  // Every BHT counter comes out of reset weakly not-taken.
  localparam logic [1:0] BHT_CNT_RST = 2'b01;

  // One training step of a 2-bit saturating counter.
  function automatic logic [1:0] bht_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Purpose     : branch history table of 2-bit saturating counters.
// Latency     : read is combinational; write takes effect at the next clk edge.
// Backpressure: none; a write is applied whenever wr_en is high.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset (all counters -> 01)
//   rd_idx / rd_taken  read port: MSB of the addressed counter
//   wr_en / wr_idx /   write port: train the addressed counter with the
//   wr_taken           resolved outcome
// A read of the index being written in the same cycle returns the old value,
// since the array is only updated at the edge.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 wr_en,
  input  logic [BHT_IDX_W-1:0] wr_idx,
  input  logic                 wr_taken
);

  localparam int DEPTH = 1 << BHT_IDX_W;

  logic [1:0] cnt_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= BHT_CNT_RST;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= bht_cnt_next(cnt_q[wr_idx], wr_taken);
    end
  end

  // Prediction is just the counter MSB (10/11 -> taken).
  assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose     : resolves branch/jump ops, flags mispredicts and trains a 2-bit BHT.
// Latency     : 1 cycle from an accepted op to out_valid/redirect/redirect_addr/link_result.
// Backpressure: stall freezes the output register and drops the input; flush kills it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (dominates all)
//   in_valid, stall, flush   op handshake / pipeline control
//   pc, bru_op, rdata1,      op PC, one-hot {jal,jalr,beq,bne,blt,bge,bltu,bgeu},
//   rdata2, imm              operands, sign-extended immediate
//   pred_taken, pred_addr    fetch-side prediction for this op
//   lookup_pc, lookup_taken  fetch-side BHT query (combinational)
//   out_valid, redirect,     registered result: valid, mispredict,
//   redirect_addr,           correct next PC,
//   link_result              pc+4 for the rd write
// Optional feature macro BRU_PERF_CNT_EN adds perf_br_cnt / perf_mis_cnt
// (64-bit counts of accepted ops and accepted mispredicts).
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_IDX_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [XLEN-1:0]     pc,
  input  logic [BRU_OP_W-1:0] bru_op,
  input  logic [XLEN-1:0]     rdata1,
  input  logic [XLEN-1:0]     rdata2,
  input  logic [XLEN-1:0]     imm,
  input  logic                pred_taken,
  input  logic [XLEN-1:0]     pred_addr,
  input  logic [XLEN-1:0]     lookup_pc,
  output logic                lookup_taken,
  output logic                out_valid,
  output logic                redirect,
  output logic [XLEN-1:0]     redirect_addr,
`ifdef BRU_PERF_CNT_EN
  output logic [63:0]         perf_br_cnt,
  output logic [63:0]         perf_mis_cnt,
`endif
  output logic [XLEN-1:0]     link_result
);

  // ---------------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------------
  logic cmp_eq;
  logic cmp_lt_s;
  logic cmp_lt_u;
  logic taken;
  logic is_cond;

  assign cmp_eq   = (rdata1 == rdata2);
  assign cmp_lt_s = ($signed(rdata1) < $signed(rdata2));
  assign cmp_lt_u = (rdata1 < rdata2);

  // An all-zero bru_op matches no term and therefore resolves not-taken.
  assign taken = bru_op[OP_JAL]
               | bru_op[OP_JALR]
               | (bru_op[OP_BEQ]  &  cmp_eq)
               | (bru_op[OP_BNE]  & ~cmp_eq)
               | (bru_op[OP_BLT]  &  cmp_lt_s)
               | (bru_op[OP_BGE]  & ~cmp_lt_s)
               | (bru_op[OP_BLTU] &  cmp_lt_u)
               | (bru_op[OP_BGEU] & ~cmp_lt_u);

  assign is_cond = |(bru_op & COND_OP_MASK);

  // ---------------------------------------------------------------------------
  // Target / fall-through and mispredict detection
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            mispredict;

  assign pc_rel_sum = pc + imm;
  assign jalr_sum   = rdata1 + imm;
  // jalr targets always have bit 0 forced low.
  assign target     = bru_op[OP_JALR] ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_sum;
  assign pc_plus4   = pc + XLEN'(4);
  assign next_pc    = taken ? target : pc_plus4;

  // A wrong target only matters when the op really is taken; a not-taken op
  // that was predicted not-taken never needs a refetch.
  assign mispredict = (taken != pred_taken) | (taken & (target != pred_addr));

  // ---------------------------------------------------------------------------
  // Acceptance: flush kills the op, stall drops it.
  // ---------------------------------------------------------------------------
  logic accept;

  assign accept = in_valid & ~stall & ~flush;

  // ---------------------------------------------------------------------------
  // BHT: trained by accepted conditional ops only, at the accepting edge.
  // ---------------------------------------------------------------------------
  bht_2bit #(
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_pc[BHT_IDX_W+1:2]),
    .rd_taken (lookup_taken),
    .wr_en    (accept & is_cond),
    .wr_idx   (pc[BHT_IDX_W+1:2]),
    .wr_taken (taken)
  );

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // flush only clears the valid/redirect qualifiers; the data fields keep their
  // last value since nothing downstream looks at them without out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
      link_result   <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      redirect      <= 1'b0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      redirect      <= in_valid & mispredict;
      if (in_valid) begin
        redirect_addr <= next_pc;
        link_result   <= pc_plus4;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters: free-running, wrap naturally at 2^64.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else if (accept) begin
      perf_br_cnt <= perf_br_cnt + 64'd1;
      if (mispredict) begin
        perf_mis_cnt <= perf_mis_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed ops push hand-computed
// results into a queue; a monitor on the falling edge pops and compares
// whenever out_valid is high. BHT behaviour is probed through lookup_pc.
module tb_branch_resolve_unit;

  localparam logic [7:0] JAL  = 8'h80;
  localparam logic [7:0] JALR = 8'h40;
  localparam logic [7:0] BEQ  = 8'h20;
  localparam logic [7:0] BNE  = 8'h10;
  localparam logic [7:0] BLT  = 8'h08;
  localparam logic [7:0] BGE  = 8'h04;
  localparam logic [7:0] BLTU = 8'h02;
  localparam logic [7:0] BGEU = 8'h01;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [63:0] pc, rdata1, rdata2, imm, pred_addr, lookup_pc;
  logic [7:0]  bru_op;
  logic        pred_taken;
  logic        lookup_taken, out_valid, redirect;
  logic [63:0] redirect_addr, link_result;
`ifdef BRU_PERF_CNT_EN
  logic [63:0] perf_br_cnt, perf_mis_cnt;
`endif

  typedef struct packed {
    logic        redirect;
    logic [63:0] addr;
    logic [63:0] link;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(64), .BHT_IDX_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .pc            (pc),
    .bru_op        (bru_op),
    .rdata1        (rdata1),
    .rdata2        (rdata2),
    .imm           (imm),
    .pred_taken    (pred_taken),
    .pred_addr     (pred_addr),
    .lookup_pc     (lookup_pc),
    .lookup_taken  (lookup_taken),
    .out_valid     (out_valid),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
`ifdef BRU_PERF_CNT_EN
    .perf_br_cnt   (perf_br_cnt),
    .perf_mis_cnt  (perf_mis_cnt),
`endif
    .link_result   (link_result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [7:0] op, input logic [63:0] p, input logic [63:0] r1,
                        input logic [63:0] r2, input logic [63:0] im,
                        input logic pt, input logic [63:0] pa);
    in_valid = 1'b1; bru_op = op; pc = p; rdata1 = r1; rdata2 = r2;
    imm = im; pred_taken = pt; pred_addr = pa;
  endtask

  task automatic idle();
    in_valid = 1'b0; bru_op = 8'h00;
  endtask

  // Push the result expected after the coming edge, then advance one cycle.
  task automatic step(input bit ev, input bit er, input logic [63:0] ea, input logic [63:0] el);
    if (ev) exp_q.push_back('{redirect: er, addr: ea, link: el});
    @(posedge clk); #1;
  endtask

  task automatic sweep_lookup(input string name);
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 64'(i) << 2;
      #1;
      chk(name, {63'd0, lookup_taken}, 64'd0);
    end
  endtask

  // Monitor: every presented result must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 expected no result");
          end else begin
            e = exp_q.pop_front();
            chk("redirect", {63'd0, redirect}, {63'd0, e.redirect});
            chk("redirect_addr", redirect_addr, e.addr);
            chk("link_result", link_result, e.link);
          end
        end else if (redirect) begin
          errors++;
          $display("FAIL redirect_without_valid: got redirect=1 expected 0");
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; lookup_pc = '0;
    pc = '0; rdata1 = '0; rdata2 = '0; imm = '0; pred_taken = 1'b0; pred_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_redirect", {63'd0, redirect}, 64'd0);
    chk("rst_redirect_addr", redirect_addr, 64'd0);
    chk("rst_link_result", link_result, 64'd0);
    sweep_lookup("rst_lookup");
    @(posedge clk); #1;
    rst = 1'b0;

    // Resolution of each op kind.
    set_op(BEQ,  64'h1000, 64'd5, 64'd5, 64'h20, 1'b0, 64'h0);      step(1, 1, 64'h1020, 64'h1004);
    set_op(JALR, 64'h3000, 64'h2001, 64'd0, 64'h4, 1'b1, 64'h2004); step(1, 0, 64'h2004, 64'h3004);
    set_op(BLTU, 64'h504, ONES, 64'd1, 64'h10, 1'b1, 64'h514);      step(1, 1, 64'h508, 64'h508);
    set_op(BLT,  64'h608, ONES, 64'd1, 64'h10, 1'b1, 64'h618);      step(1, 0, 64'h618, 64'h60C);
    set_op(BNE,  64'h70C, 64'd7, 64'd7, 64'h40, 1'b0, 64'h0);       step(1, 0, 64'h710, 64'h710);
    set_op(BGE,  64'h810, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB,
           64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'h800);                 step(1, 1, 64'h808, 64'h814);
    set_op(BGEU, 64'h814, 64'd1, ONES, 64'h40, 1'b0, 64'h0);        step(1, 0, 64'h818, 64'h818);
    set_op(JAL,  64'h900, 64'd0, 64'd0, 64'h100, 1'b0, 64'h0);      step(1, 1, 64'hA00, 64'h904);
    set_op(8'h00, 64'h904, 64'd0, 64'd0, 64'h20, 1'b0, 64'h0);      step(1, 0, 64'h908, 64'h908);
    idle(); step(0, 0, 0, 0);

    // BHT training at pc 0x40 (index 16): 01 -> 10 -> 11 -> 11 -> 11.
    lookup_pc = 64'h40; #1;
    chk("bht_init_40", {63'd0, lookup_taken}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      set_op(BEQ, 64'h40, 64'd9, 64'd9, 64'h8, 1'b1, 64'h48);
      #1;
      chk("bht_same_cycle_40", {63'd0, lookup_taken}, (k == 0) ? 64'd0 : 64'd1);
      step(1, 0, 64'h48, 64'h44);
      chk("bht_after_taken_40", {63'd0, lookup_taken}, 64'd1);
    end
    // Two not-taken from saturation: 11 -> 10 (still taken) -> 01.
    set_op(BEQ, 64'h40, 64'd9, 64'd8, 64'h8, 1'b1, 64'h48); step(1, 1, 64'h44, 64'h44);
    chk("bht_dec1_40", {63'd0, lookup_taken}, 64'd1);
    step(1, 1, 64'h44, 64'h44);
    chk("bht_dec2_40", {63'd0, lookup_taken}, 64'd0);
    idle();
    lookup_pc = 64'h44; #1;
    chk("bht_neighbor_44", {63'd0, lookup_taken}, 64'd0);
    step(0, 0, 0, 0);

    // Stall holds outputs and blocks BHT training; flush with stall kills.
    lookup_pc = 64'h80;
    set_op(BEQ, 64'h80, 64'd1, 64'd1, 64'h20, 1'b0, 64'h0); step(1, 1, 64'hA0, 64'h84);
    chk("bht_taken_80", {63'd0, lookup_taken}, 64'd1);
    stall = 1'b1;
    set_op(BEQ, 64'h80, 64'd1, 64'd2, 64'h20, 1'b1, 64'hA0);
    for (int k = 0; k < 3; k++) step(1, 1, 64'hA0, 64'h84);
    chk("bht_stall_80", {63'd0, lookup_taken}, 64'd1);
    flush = 1'b1; step(0, 0, 0, 0);
    chk("flush_stall_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_stall_redirect", {63'd0, redirect}, 64'd0);
    // Flush without stall drops the op and leaves the BHT alone.
    stall = 1'b0; step(0, 0, 0, 0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bht_flush_80", {63'd0, lookup_taken}, 64'd1);
    flush = 1'b0; idle(); step(0, 0, 0, 0);

`ifdef BRU_PERF_CNT_EN
    chk("perf_br_cnt", perf_br_cnt, 64'd16);
    chk("perf_mis_cnt", perf_mis_cnt, 64'd7);
`endif

    // Reset mid-stream with an op presented: op dropped, all state cleared.
    set_op(BEQ, 64'h1000, 64'd5, 64'd5, 64'h20, 1'b0, 64'h0);
    rst = 1'b1; step(0, 0, 0, 0);
    rst = 1'b0; idle();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_redirect", {63'd0, redirect}, 64'd0);
    chk("midrst_redirect_addr", redirect_addr, 64'd0);
    chk("midrst_link_result", link_result, 64'd0);
`ifdef BRU_PERF_CNT_EN
    chk("midrst_perf_br_cnt", perf_br_cnt, 64'd0);
    chk("midrst_perf_mis_cnt", perf_mis_cnt, 64'd0);
`endif
    sweep_lookup("midrst_lookup");
    @(posedge clk); #1;

    // Normal operation resumes after reset.
    set_op(BNE, 64'h1000, 64'd1, 64'd2, 64'h20, 1'b1, 64'h1020); step(1, 0, 64'h1020, 64'h1004);
    idle(); step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
